// File: rtl/ones_pattern_gen_if.sv
// Stream bundle for ones_pattern_gen: request side (start, numOnes),
// word stream (pattern, valid, ready, last, index) and status pulses.
interface ones_pattern_gen_if;
   logic       start;
   logic [3:0] numOnes;
   logic       ready;
   logic [7:0] pattern;
   logic       valid;
   logic       last;
   logic [6:0] index;
   logic       busy;
   logic       done;
   logic       error;

   modport master (
      input  start, numOnes, ready,
      output pattern, valid, last, index, busy, done, error
   );

   modport slave (
      output start, numOnes, ready,
      input  pattern, valid, last, index, busy, done, error
   );
endinterface

// File: rtl/ones_pattern_gen.sv
// Enumerates all 8-bit words with popcount k in ascending order.
// Ports: clk, reset (async high), bus (master: start/numOnes/ready in,
// pattern/valid/last/index/busy/done/error out).
module ones_pattern_gen (
   input  logic clk,
   input  logic reset,
   ones_pattern_gen_if.master bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state_q, state_d;
   logic [3:0] k_q, k_d;
   logic [7:0] pattern_q, pattern_d;
   logic [6:0] index_q, index_d;
   logic       valid_q, valid_d;
   logic       last_q, last_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       error_q, error_d;

   // k ones in the low bits: first word of a sequence
   function automatic logic [7:0] low_mask(input logic [3:0] k);
      return ~(8'hFF << k);
   endfunction

   // k ones in the high bits: final word of a sequence
   function automatic logic [7:0] top_mask(input logic [3:0] k);
      return ~(8'hFF >> k);
   endfunction

   // Gosper successor in 9 bits so the ripple carry out of bit 7
   // survives; the divide by the lowest set bit is a right shift.
   logic [8:0] x9, c9, r9, t9, next9;
   logic [2:0] ctz;
   logic       gosper_unused;

   always_comb begin
      x9  = {1'b0, pattern_q};
      c9  = x9 & (~x9 + 9'd1);
      r9  = x9 + c9;
      ctz = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pattern_q[i]) ctz = 3'(i);
      end
      t9    = ((r9 ^ x9) >> 2) >> ctz;
      next9 = t9 | r9;
   end

   // successor is never taken on the last word, so bit 8 stays clear
   assign gosper_unused = next9[8];

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      pattern_d = pattern_q;
      index_d   = index_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.numOnes > 4'd8) begin
                  error_d = 1'b1;
               end else begin
                  state_d   = RUN;
                  k_d       = bus.numOnes;
                  pattern_d = low_mask(bus.numOnes);
                  index_d   = 7'd0;
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
                  // only k=0 and k=8 start on their final word
                  last_d    = low_mask(bus.numOnes)
                              == top_mask(bus.numOnes);
               end
            end
         end
         RUN: begin
            if (bus.ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pattern_d = next9[7:0];
                  index_d   = index_q + 7'd1;
                  last_d    = next9[7:0] == top_mask(k_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         k_q       <= 4'd0;
         pattern_q <= 8'h00;
         index_q   <= 7'd0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         pattern_q <= pattern_d;
         index_q   <= index_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign bus.pattern = pattern_q;
   assign bus.valid   = valid_q;
   assign bus.last    = last_q;
   assign bus.index   = index_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.error   = error_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: sequences for k=0,1,2,3,4,8,
// stalls, errors, mid-run reset and ignored starts.
module tb_ones_pattern_gen;

   logic clk;
   logic reset;
   int   checks;
   int   fails;

   ones_pattern_gen_if bus ();

   ones_pattern_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.numOnes = 4'd0;
      bus.ready   = 1'b0;
      #3;
      checks++;
      if ({bus.pattern, bus.valid, bus.last, bus.index,
           bus.busy, bus.done, bus.error} !== 21'd0) begin
         fails++;
         $display("FAIL reset_outputs pat=%h v=%b l=%b idx=%0d b=%b d=%b e=%b want all 0",
                  bus.pattern, bus.valid, bus.last, bus.index,
                  bus.busy, bus.done, bus.error);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_reset v=%b b=%b want 0 0",
                  bus.valid, bus.busy);
      end
   endtask

   task automatic test_k2();
      logic [7:0] exp [28] = '{
         8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h11,
         8'h12, 8'h14, 8'h18, 8'h21, 8'h22, 8'h24, 8'h28,
         8'h30, 8'h41, 8'h42, 8'h44, 8'h48, 8'h50, 8'h60,
         8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'hC0};
      bus.start   = 1'b1;
      bus.numOnes = 4'd2;
      bus.ready   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 28; i++) begin
         checks++;
         if (bus.valid !== 1'b1 || bus.pattern !== exp[i] ||
             bus.index !== 7'(i) || bus.last !== (i == 27) ||
             bus.done !== 1'b0) begin
            fails++;
            $display("FAIL k2_word%0d v=%b pat=%h idx=%0d l=%b d=%b want 1 %h %0d %b 0",
                     i, bus.valid, bus.pattern, bus.index, bus.last,
                     bus.done, exp[i], i, i == 27);
         end
         tick();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
         fails++;
         $display("FAIL k2_done d=%b b=%b v=%b want 1 0 0",
                  bus.done, bus.busy, bus.valid);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
         fails++;
         $display("FAIL k2_done_width d=%b want 0", bus.done);
      end
   endtask

   task automatic test_k4_stall();
      logic [7:0] p_pat;
      logic [6:0] p_idx;
      logic       p_last;
      logic       fired;
      logic       seen_done;
      int         xfers;
      int         cyc;
      int         bad;
      bus.start   = 1'b1;
      bus.numOnes = 4'd4;
      bus.ready   = 1'b0;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.valid !== 1'b1 || bus.pattern !== 8'h0F || bus.index !== 7'd0) begin
         fails++;
         $display("FAIL k4_first v=%b pat=%h idx=%0d want 1 0f 0",
                  bus.valid, bus.pattern, bus.index);
      end
      xfers     = 0;
      cyc       = 0;
      bad       = 0;
      seen_done = 1'b0;
      while (!seen_done && cyc < 600) begin
         p_pat     = bus.pattern;
         p_idx     = bus.index;
         p_last    = bus.last;
         bus.ready = 1'($urandom_range(0, 1));
         fired     = bus.ready;
         tick();
         cyc++;
         if (fired) begin
            xfers++;
            if (p_last) begin
               seen_done = 1'b1;
               if (p_pat !== 8'hF0 || p_idx !== 7'd69 || bus.done !== 1'b1) bad++;
            end else if (bus.valid !== 1'b1 || bus.pattern <= p_pat ||
                         $countones(bus.pattern) != 4 ||
                         bus.index !== p_idx + 7'd1) begin
               bad++;
            end
         end else if (bus.pattern !== p_pat || bus.index !== p_idx ||
                      bus.last !== p_last || bus.valid !== 1'b1) begin
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL k4_stream bad_cycles=%0d want 0", bad);
      end
      checks++;
      if (xfers != 70 || !seen_done) begin
         fails++;
         $display("FAIL k4_count transfers=%0d done_seen=%b want 70 1",
                  xfers, seen_done);
      end
      bus.ready = 1'b0;
      tick();
   endtask

   task automatic test_single(input logic [3:0] k, input logic [7:0] w);
      bus.start   = 1'b1;
      bus.numOnes = k;
      bus.ready   = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.valid !== 1'b1 || bus.last !== 1'b1 || bus.pattern !== w ||
          bus.busy !== 1'b1 || bus.index !== 7'd0) begin
         fails++;
         $display("FAIL single_k%0d v=%b l=%b pat=%h b=%b idx=%0d want 1 1 %h 1 0",
                  k, bus.valid, bus.last, bus.pattern, bus.busy,
                  bus.index, w);
      end
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
         fails++;
         $display("FAIL single_k%0d_done d=%b b=%b v=%b want 1 0 0",
                  k, bus.done, bus.busy, bus.valid);
      end
      tick();
   endtask

   task automatic test_error(input logic [3:0] k);
      bus.start   = 1'b1;
      bus.numOnes = k;
      bus.ready   = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.error !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL error_k%0d e=%b v=%b b=%b want 1 0 0",
                  k, bus.error, bus.valid, bus.busy);
      end
      tick();
      checks++;
      if (bus.error !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL error_k%0d_pulse e=%b v=%b b=%b want 0 0 0",
                  k, bus.error, bus.valid, bus.busy);
      end
   endtask

   task automatic test_reset_abort();
      int dones;
      bus.start   = 1'b1;
      bus.numOnes = 4'd3;
      bus.ready   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      // words 07 0b 0d 0e 13 15 16 19 1a 1c 23 -> index 10 is 0x23
      checks++;
      if (bus.pattern !== 8'h23 || bus.index !== 7'd10) begin
         fails++;
         $display("FAIL k3_word10 pat=%h idx=%0d want 23 10",
                  bus.pattern, bus.index);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.pattern, bus.valid, bus.last, bus.index,
           bus.busy, bus.done, bus.error} !== 21'd0) begin
         fails++;
         $display("FAIL abort_outputs pat=%h v=%b l=%b idx=%0d b=%b d=%b want all 0",
                  bus.pattern, bus.valid, bus.last, bus.index,
                  bus.busy, bus.done);
      end
      tick();
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.valid === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         fails++;
         $display("FAIL abort_quiet stray_cycles=%0d want 0", dones);
      end
      bus.start   = 1'b1;
      bus.numOnes = 4'd3;
      bus.ready   = 1'b0;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.valid !== 1'b1 || bus.pattern !== 8'h07 || bus.index !== 7'd0) begin
         fails++;
         $display("FAIL k3_restart v=%b pat=%h idx=%0d want 1 07 0",
                  bus.valid, bus.pattern, bus.index);
      end
      #2;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      bus.start   = 1'b1;
      bus.numOnes = 4'd1;
      bus.ready   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.valid !== 1'b1 || bus.pattern !== 8'(1 << i) ||
             bus.index !== 7'(i) || bus.last !== (i == 7)) begin
            fails++;
            $display("FAIL k1_word%0d v=%b pat=%h idx=%0d l=%b want 1 %h %0d %b",
                     i, bus.valid, bus.pattern, bus.index, bus.last,
                     8'(1 << i), i, i == 7);
         end
         bus.start   = (i == 3) || (i == 7);
         bus.numOnes = (i == 7) ? 4'd2 : 4'd5;
         tick();
         bus.start = 1'b0;
      end
      checks++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL k1_done d=%b v=%b b=%b want 1 0 0",
                  bus.done, bus.valid, bus.busy);
      end
      bus.start   = 1'b1;
      bus.numOnes = 4'd1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.valid !== 1'b1 || bus.pattern !== 8'h01 || bus.index !== 7'd0) begin
         fails++;
         $display("FAIL k1_restart v=%b pat=%h idx=%0d want 1 01 0",
                  bus.valid, bus.pattern, bus.index);
      end
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc != 8) begin
         fails++;
         $display("FAIL k1_second_len cycles=%0d want 8", cyc);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_k2();
      test_k4_stall();
      test_single(4'd0, 8'h00);
      test_single(4'd8, 8'hFF);
      test_error(4'd9);
      test_error(4'd15);
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/ones_pattern_gen.md
# ones_pattern_gen

Sequential generator that enumerates, in ascending numeric order, every 8-bit word whose population count equals a requested value. It is the inverse companion of the team's 8-bit ones counter: the counter maps a word to its number of ones, and this block maps a number of ones to all matching words. Output is streamed one word per accepted transfer over a valid/ready interface. Typical uses are exhaustive stimulus generation and constrained pattern sweeps.

## Interface

- Parameters: none. Word width is fixed at 8 and the index width at 7 (C(8,4) = 70 is the largest sequence length).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
- numOnes  input  4  requested popcount k; sampled when start is accepted.
- ready  input  1  downstream can accept pattern this cycle.
- pattern  output  8  current word; popcount always equals the latched k.
- valid  output  1  pattern is valid.
- last  output  1  pattern is the final word of the sequence; qualified by valid.
- index  output  7  0-based position of pattern within the sequence.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse after the last word is transferred.
- error  output  1  one-cycle pulse when start is given with numOnes > 8.

## Operation

- States: IDLE, RUN.
- IDLE with start=1 and numOnes ≤ 8:
  - latch k;
  - load pattern = (1<<k)-1 and index = 0;
  - enter RUN.
- IDLE with start=1 and numOnes > 8: pulse error next cycle, stay in IDLE, valid stays 0.
- RUN: valid = 1, busy = 1.
- A transfer occurs on a cycle with valid=1 and ready=1.
- On a transfer that is not last:
  - pattern ← smallest 8-bit value greater than the current pattern with the same popcount (Gosper successor);
  - index ← index+1.
- last = 1 exactly when pattern == ((1<<k)-1) << (8-k) (the top k bits set).
- k=0 and k=8 each produce a single word, 0x00 and 0xFF, with last=1 on it.
- On a transfer with last=1: go to IDLE, pulse done next cycle, clear valid/last/busy.
- start is ignored while in RUN, including on the same cycle as the final transfer. The earliest restart is the cycle after done is asserted.
- Successor arithmetic is carried out in 9 bits or wider so the carry out of bit 7 is never lost. The successor is never applied to the last word.
- Sequence lengths are C(8,k): 1, 8, 28, 56, 70, 56, 28, 8, 1 for k = 0..8.

## Timing

- Reset values of all outputs: pattern=0x00, valid=0, last=0, index=0, busy=0, done=0, error=0.
- Reset asserted mid-sequence aborts immediately: outputs return to reset values with no done pulse.
- Latency:
  - start accepted at edge N: valid=1 with the first word after edge N;
  - error: asserted after edge N for one cycle.
- Holding: while valid=1 and ready=0, pattern, index and last are held stable.
- Throughput: with ready held high, one word per cycle and no bubbles. A 70-word sequence occupies exactly 70 cycles of valid.
- done: asserted for the one cycle following the edge that accepted the last transfer. busy is 0 in that same cycle.
- ready is ignored while valid=0.

## Test plan

- k=2, ready always 1 -> 28 consecutive words 0x03, 0x05, 0x06, 0x09, 0x0A, 0x0C, 0x11 ... 0xA0, 0xC0; last only on 0xC0 (index 27); done one cycle later.
- k=4, ready driven pseudo-randomly -> 70 transfers, strictly ascending, each popcount 4, first 0x0F, last 0xF0 at index 69; pattern stable on every stalled cycle.
- k=0 and k=8 -> single word 0x00 (or 0xFF) with valid=1 and last=1; done follows; busy high for exactly one cycle.
- numOnes=9 and numOnes=15 -> error pulses one cycle, valid never asserted, busy stays 0.
- k=3, assert reset after the 10th transfer -> all outputs return to reset values asynchronously, no done pulse; a following start with k=3 restarts at 0x07, index 0.
- k=1, start pulsed while in RUN and again on the final-transfer cycle -> both ignored; exactly 8 words 0x01..0x80 are produced; a start in the cycle after done begins a new sequence.
